// File: rtl/axis_wc_4_to_1.sv
// AXI4-Stream 32-bit to 8-bit width down-converter. It emits lane 0 first and carries TUSER for each lane.
// Define AXIS_WC_4_TO_1_TLAST_EN to add the s_axis_tlast/m_axis_tlast ports and the tlast flag.
module axis_wc_4_to_1 #(
    parameter int TUSER_BYTE_WIDTH = 1
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,
    input  logic [31:0]                   s_axis_tdata,
    input  logic [4*TUSER_BYTE_WIDTH-1:0] s_axis_tuser,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
`ifdef AXIS_WC_4_TO_1_TLAST_EN
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tlast,
`endif
    output logic [7:0]                    m_axis_tdata,
    output logic [TUSER_BYTE_WIDTH-1:0]   m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    logic [31:0]                   hold_q, hold_d;
    logic [4*TUSER_BYTE_WIDTH-1:0] user_q, user_d;
    logic                          full_q, full_d;
    logic [1:0]                    idx_q, idx_d;
    logic                          in_xfer;
    logic                          out_xfer;

    // Handshake: a transfer occurs on a rising edge where valid && ready. Valid never waits on ready.
    // Ready may rise during lane 3 so that the next word loads on the edge where lane 3 leaves.
    assign s_axis_tready = !axis_reset && (!full_q || (m_axis_tready && idx_q == 2'd3));
    assign in_xfer       = s_axis_tvalid && s_axis_tready;
    assign out_xfer      = m_axis_tvalid && m_axis_tready;

    assign m_axis_tvalid = full_q && !axis_reset;
    assign m_axis_tdata  = axis_reset ? 8'd0 : hold_q[{idx_q, 3'b000} +: 8];
    assign m_axis_tuser  = axis_reset ? '0
                         : user_q[int'(idx_q) * TUSER_BYTE_WIDTH +: TUSER_BYTE_WIDTH];

`ifdef AXIS_WC_4_TO_1_TLAST_EN
    logic tlast_q, tlast_d;

    assign m_axis_tlast = !axis_reset && tlast_q && idx_q == 2'd3;

    always_comb begin
        tlast_d = tlast_q;
        if (in_xfer) begin
            tlast_d = s_axis_tlast;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            tlast_q <= 1'b0;
        end else begin
            tlast_q <= tlast_d;
        end
    end
`endif

    // If lane 3 leaves and a new word loads on the same edge, the load takes priority, so full stays set.
    always_comb begin
        hold_d = hold_q;
        user_d = user_q;
        full_d = full_q;
        idx_d  = idx_q;
        if (out_xfer) begin
            if (idx_q == 2'd3) begin
                full_d = 1'b0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
        if (in_xfer) begin
            hold_d = s_axis_tdata;
            user_d = s_axis_tuser;
            full_d = 1'b1;
            idx_d  = 2'd0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            hold_q <= '0;
            user_q <= '0;
            full_q <= 1'b0;
            idx_q  <= 2'd0;
        end else begin
            hold_q <= hold_d;
            user_q <= user_d;
            full_q <= full_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: tb/tb_axis_wc_4_to_1.sv
// Bench for axis_wc_4_to_1. It checks directed vector tables and corner-case sequences.
// It also sends random traffic, which a lane-queue reference model checks.
module tb_axis_wc_4_to_1;
  localparam int UW = 1;
  localparam int EW = 9 + UW;  // {last, user, byte}

  logic              clk = 1'b0;
  logic              axis_reset;
  logic [31:0]       s_tdata;
  logic [4*UW-1:0]   s_tuser;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic [7:0]        m_tdata;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  always #5 clk = ~clk;

  axis_wc_4_to_1 #(.TUSER_BYTE_WIDTH(UW)) dut (
    .axis_aclk     (clk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
`ifdef AXIS_WC_4_TO_1_TLAST_EN
    .s_axis_tlast  (s_tlast),
    .m_axis_tlast  (m_tlast),
`endif
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );
`ifndef AXIS_WC_4_TO_1_TLAST_EN
  assign m_tlast = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int got_cyc[$];
  logic exp_rdy;
  logic in_last;
  int mr_mode = 0;  // 0: main process drives m_tready, 1: fixed pattern, 2: random
  logic [6:0] pat = 7'b1101001;  // 1,0,0,1,0,1,1 starting at bit 0

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted word becomes four queued lanes. Outputs pop from the front.
  always @(negedge clk) begin
    cyc++;
    if (axis_reset) begin
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_m_tdata", 32'(m_tdata), 32'd0);
      chk("rst_m_tuser", 32'(m_tuser), 32'd0);
      chk("rst_m_tlast", 32'(m_tlast), 32'd0);
      exp_q.delete();
    end else begin
      exp_rdy = (exp_q.size() == 0) || (m_tready && exp_q.size() == 1);
      chk("s_tready", 32'(s_tready), 32'(exp_rdy));
      chk("m_tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
      if (m_tvalid && exp_q.size() != 0)
        chk("m_lane", 32'({m_tlast, m_tuser, m_tdata}), 32'(exp_q[0]));
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tuser, m_tdata});
        got_cyc.push_back(cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_tvalid && s_tready) begin
        acc_cyc = cyc;
`ifdef AXIS_WC_4_TO_1_TLAST_EN
        in_last = s_tlast;
`else
        in_last = 1'b0;
`endif
        for (int k = 0; k < 4; k++)
          exp_q.push_back({in_last && k == 3, s_tuser[k*UW +: UW], s_tdata[8*k +: 8]});
      end
    end
  end

  initial begin
    int p;
    p = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mr_mode == 1) begin
        m_tready = pat[p % 7];
        p++;
      end else if (mr_mode == 2) begin
        m_tready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [4*UW-1:0] u, input logic l);
    int t;
    logic hs;
    s_tdata = d;
    s_tuser = u;
    s_tlast = l;
    s_tvalid = 1'b1;
    t = 0;
    hs = 1'b0;
    do begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 200);
    if (!hs) chk("send_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("output_count", 32'(got_q.size()), 32'(n));
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  u;
    logic [7:0]  e0, e1, e2, e3;
    logic        eu0, eu1, eu2, eu3;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    axis_reset = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tuser = '0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    vecs[0] = '{32'hDDCCBBAA, 4'b0101, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h12345678, 4'b1000, 8'h78, 8'h56, 8'h34, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hFFEEDD00, 4'b0011, 8'h00, 8'hDD, 8'hEE, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h5A5AA5A5, 4'b1110, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1};

    repeat (4) @(posedge clk);
    #1;
    axis_reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;

    // Single-word vectors, output always ready
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      got_cyc.delete();
      send(vecs[i].d, vecs[i].u, 1'b0);
      wait_got(4);
      if (got_q.size() == 4) begin
        chk("vec_b0", 32'(got_q[0][8:0]), 32'({vecs[i].eu0, vecs[i].e0}));
        chk("vec_b1", 32'(got_q[1][8:0]), 32'({vecs[i].eu1, vecs[i].e1}));
        chk("vec_b2", 32'(got_q[2][8:0]), 32'({vecs[i].eu2, vecs[i].e2}));
        chk("vec_b3", 32'(got_q[3][8:0]), 32'({vecs[i].eu3, vecs[i].e3}));
        chk("vec_latency", 32'(got_cyc[0]), 32'(acc_cyc + 1));
        chk("vec_no_gap", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
      end
      @(negedge clk);
      chk("vec_valid_drop", 32'(m_tvalid), 32'd0);
      @(posedge clk);
      #1;
    end

    // Back-to-back streaming, which includes a lane-3 output and a new input on the same edge
    got_q.delete();
    got_cyc.delete();
    send(32'h03020100, 4'h0, 1'b0);
    send(32'h07060504, 4'h0, 1'b0);
    send(32'h0B0A0908, 4'h0, 1'b0);
    wait_got(12);
    if (got_q.size() == 12)
      for (int i = 0; i < 12; i++) begin
        chk("stream_byte", 32'(got_q[i][7:0]), 32'(i));
        chk("stream_cycle", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
      end

    // Back-pressure pattern
    repeat (3) @(posedge clk);
    #1;
    got_q.delete();
    mr_mode = 1;
    send(32'hA3A2A1A0, 4'h0, 1'b0);
    send(32'hB3B2B1B0, 4'h0, 1'b0);
    wait_got(8);
    mr_mode = 0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    if (got_q.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("bp_byte", 32'(got_q[i][7:0]), 32'(i < 4 ? 8'hA0 + i : 8'hB0 + i - 4));

    // Reset after two lanes of a word
    repeat (2) @(posedge clk);
    #1;
    m_tready = 1'b0;
    send(32'h44332211, 4'h0, 1'b0);
    got_q.delete();
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    axis_reset = 1'b1;
    @(posedge clk);
    #1;
    axis_reset = 1'b0;
    chk("midrst_count", 32'(got_q.size()), 32'd2);
    send(32'h88776655, 4'h0, 1'b0);
    wait_got(6);
    if (got_q.size() == 6) begin
      chk("midrst_b0", 32'(got_q[0][7:0]), 32'h11);
      chk("midrst_b1", 32'(got_q[1][7:0]), 32'h22);
      chk("midrst_b2", 32'(got_q[2][7:0]), 32'h55);
      chk("midrst_b3", 32'(got_q[3][7:0]), 32'h66);
      chk("midrst_b4", 32'(got_q[4][7:0]), 32'h77);
      chk("midrst_b5", 32'(got_q[5][7:0]), 32'h88);
    end

`ifdef AXIS_WC_4_TO_1_TLAST_EN
    repeat (2) @(posedge clk);
    #1;
    got_q.delete();
    send(32'h11111111, 4'h0, 1'b0);
    send(32'h22222222, 4'h0, 1'b1);
    wait_got(8);
    if (got_q.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("tlast_pos", 32'(got_q[i][EW-1]), 32'(i == 7));
`endif

    // Random traffic with random output ready
    mr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      rd = $urandom;
      send(rd, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    mr_mode = 0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
